// File: rtl/tw_tracker.sv
// Taskwait tracker: per-parent outstanding-child counters with ACK issue once a
// waiting parent's count returns to zero. One command is processed every three cycles.
module tw_tracker #(
  parameter int unsigned TW_MEM_SIZE = 16,
  parameter int unsigned ACCID_W     = 8,
  parameter int unsigned TASKID_W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_type,
  input  logic [TASKID_W-1:0] in_taskid,
  input  logic [ACCID_W-1:0]  in_accid,
  input  logic [31:0]         in_components,
  output logic                ack_valid,
  input  logic                ack_ready,
  output logic [ACCID_W-1:0]  ack_accid,
  output logic [7:0]          ack_code,
  output logic                full_err,
  output logic                busy
);

  localparam int unsigned IDX_W  = $clog2(TW_MEM_SIZE);
  localparam logic [7:0]  ACK_OK = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    UPDATE,
    ACK
  } state_t;

  state_t state, state_nxt;

  logic [TW_MEM_SIZE-1:0] ent_valid;
  logic [TW_MEM_SIZE-1:0] ent_armed;
  logic [ACCID_W-1:0]     ent_accid  [TW_MEM_SIZE];
  logic signed [32:0]     ent_cnt    [TW_MEM_SIZE];
  logic [TASKID_W-1:0]    ent_taskid [TW_MEM_SIZE];

  logic                cmd_type;
  logic [TASKID_W-1:0] cmd_taskid;
  logic [ACCID_W-1:0]  cmd_accid;
  logic [31:0]         cmd_comp;

  logic             hit_c, free_c, hit_q, free_q;
  logic [IDX_W-1:0] hit_idx_c, free_idx_c, hit_idx_q, free_idx_q;

  logic [IDX_W-1:0]   upd_idx;
  logic               drop;
  logic               done;
  logic signed [32:0] comp_ext;
  logic signed [32:0] cur_cnt, new_cnt;
  logic               cur_armed, new_armed;
  logic [ACCID_W-1:0] cur_accid, new_accid;

  // Exact-match lookup over valid entries, plus lowest-index free slot.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int unsigned i = 0; i < TW_MEM_SIZE; i++) begin
      if (!hit_c && ent_valid[i] && (ent_taskid[i] == cmd_taskid)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!free_c && !ent_valid[i]) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  // A miss starts from a zero count, so allocate and update share one path.
  always_comb begin
    upd_idx  = hit_q ? hit_idx_q : free_idx_q;
    drop     = !hit_q && !free_q;
    comp_ext = $signed({1'b0, cmd_comp});
    if (hit_q) begin
      cur_cnt   = ent_cnt[upd_idx];
      cur_armed = ent_armed[upd_idx];
      cur_accid = ent_accid[upd_idx];
    end else begin
      cur_cnt   = '0;
      cur_armed = 1'b0;
      cur_accid = '0;
    end
    if (cmd_type) begin
      new_cnt   = cur_cnt + comp_ext;
      new_armed = 1'b1;
      new_accid = cmd_accid;
    end else begin
      new_cnt   = cur_cnt - comp_ext;
      new_armed = cur_armed;
      new_accid = cur_accid;
    end
    done = !drop && new_armed && (new_cnt == '0);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ack_valid = 1'b0;
    busy      = 1'b1;
    ack_code  = ACK_OK;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_nxt = SEARCH;
        end
      end
      SEARCH: state_nxt = UPDATE;
      UPDATE: state_nxt = done ? ACK : IDLE;
      ACK: begin
        ack_valid = 1'b1;
        if (ack_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_type   <= 1'b0;
      cmd_taskid <= '0;
      cmd_accid  <= '0;
      cmd_comp   <= '0;
      hit_q      <= 1'b0;
      free_q     <= 1'b0;
      hit_idx_q  <= '0;
      free_idx_q <= '0;
      ack_accid  <= '0;
      full_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        cmd_type   <= in_type;
        cmd_taskid <= in_taskid;
        cmd_accid  <= in_accid;
        cmd_comp   <= in_components;
      end
      if (state == SEARCH) begin
        hit_q      <= hit_c;
        free_q     <= free_c;
        hit_idx_q  <= hit_idx_c;
        free_idx_q <= free_idx_c;
      end
      if (state == UPDATE) begin
        if (drop) begin
          full_err <= 1'b1;
        end else if (done) begin
          ack_accid <= new_accid;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_armed <= '0;
      for (int unsigned i = 0; i < TW_MEM_SIZE; i++) begin
        ent_accid[i]  <= '0;
        ent_cnt[i]    <= '0;
        ent_taskid[i] <= '0;
      end
    end else if (state == UPDATE && !drop) begin
      if (done) begin
        ent_valid[upd_idx] <= 1'b0;
        ent_armed[upd_idx] <= 1'b0;
      end else begin
        ent_valid[upd_idx]  <= 1'b1;
        ent_armed[upd_idx]  <= new_armed;
        ent_accid[upd_idx]  <= new_accid;
        ent_cnt[upd_idx]    <= new_cnt;
        ent_taskid[upd_idx] <= cmd_taskid;
      end
    end
  end

endmodule

// File: tb/tb_tw_tracker.sv
// Bench for tw_tracker: a keyed-table model predicts every output each cycle,
// and directed literal checks pin latency, ACK targets and the full flag.
module tb_tw_tracker;

  localparam int unsigned SIZE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_type = 1'b0;
  logic [63:0] in_taskid = '0;
  logic [7:0]  in_accid = '0;
  logic [31:0] in_components = '0;
  logic        ack_valid;
  logic        ack_ready = 1'b1;
  logic [7:0]  ack_accid;
  logic [7:0]  ack_code;
  logic        full_err;
  logic        busy;

  tw_tracker #(.TW_MEM_SIZE(SIZE), .ACCID_W(8), .TASKID_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_taskid(in_taskid), .in_accid(in_accid), .in_components(in_components),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_accid(ack_accid),
    .ack_code(ack_code), .full_err(full_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Model: a keyed table holding each parent's count, armed flag and waiter.
  // A command takes effect two cycles after acceptance; the ACK then waits for ack_ready.
  longint      m_cnt [logic [63:0]];
  bit          m_arm [logic [63:0]];
  logic [7:0]  m_acc [logic [63:0]];
  bit          m_started = 0;
  int          m_lat = 0;
  bit          m_ack = 0;
  logic [7:0]  m_ack_accid = '0;
  bit          m_full = 0;
  bit          p_type;
  logic [63:0] p_id;
  logic [7:0]  p_accid;
  logic [31:0] p_comp;

  function automatic void model_apply();
    if (!m_cnt.exists(p_id) && m_cnt.num() >= SIZE) begin
      m_full = 1;
      return;
    end
    if (!m_cnt.exists(p_id)) begin
      m_cnt[p_id] = 0;
      m_arm[p_id] = 0;
      m_acc[p_id] = '0;
    end
    if (p_type) begin
      m_cnt[p_id] = m_cnt[p_id] + longint'(p_comp);
      m_arm[p_id] = 1;
      m_acc[p_id] = p_accid;
    end else begin
      m_cnt[p_id] = m_cnt[p_id] - longint'(p_comp);
    end
    if (m_arm[p_id] && m_cnt[p_id] == 0) begin
      m_ack       = 1;
      m_ack_accid = m_acc[p_id];
      m_cnt.delete(p_id);
      m_arm.delete(p_id);
      m_acc.delete(p_id);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1;
      m_cnt.delete();
      m_arm.delete();
      m_acc.delete();
      m_lat = 0;
      m_ack = 0;
      m_ack_accid = '0;
      m_full = 0;
    end else if (m_ack) begin
      if (ack_ready) m_ack = 0;
    end else if (m_lat > 0) begin
      m_lat--;
      if (m_lat == 0) model_apply();
    end else if (in_valid) begin
      p_type  = in_type;
      p_id    = in_taskid;
      p_accid = in_accid;
      p_comp  = in_components;
      m_lat   = 2;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!rst && m_lat == 0 && !m_ack)});
      chk("ack_valid", {63'd0, ack_valid}, {63'd0, m_ack});
      chk("busy", {63'd0, busy}, {63'd0, (m_lat > 0 || m_ack)});
      chk("full_err", {63'd0, full_err}, {63'd0, m_full});
      chk("ack_code", {56'd0, ack_code}, 64'h01);
      chk("ack_accid", {56'd0, ack_accid}, {56'd0, m_ack_accid});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit t, input logic [63:0] id, input logic [7:0] a,
                      input logic [31:0] c);
    bit done = 0;
    in_type = t;
    in_taskid = id;
    in_accid = a;
    in_components = c;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        last_acc = cyc;
        done = 1;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ack(input logic [7:0] exp_accid);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_valid) begin
        seen = 1;
        chk("ack_latency", 64'(cyc - last_acc), 64'd3);
        chk("ack_target", {56'd0, ack_accid}, {56'd0, exp_accid});
        chk("ack_code_lit", {56'd0, ack_code}, 64'h01);
      end
    end
    if (!seen) chk("ack_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    if (!seen) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_ack_valid", {63'd0, ack_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_full_err", {63'd0, full_err}, 64'd0);
    chk("rst_ack_accid", {56'd0, ack_accid}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Taskwait first, then two completions.
    send(1'b1, 64'h10, 8'd3, 32'd2);
    send(1'b0, 64'h10, 8'd0, 32'd1);
    send(1'b0, 64'h10, 8'd0, 32'd1);
    wait_ack(8'd3);

    // Completions arrive before the taskwait.
    for (int i = 0; i < 3; i++) send(1'b0, 64'h20, 8'd0, 32'd1);
    send(1'b1, 64'h20, 8'd5, 32'd3);
    wait_ack(8'd5);

    // Zero-child taskwait acknowledges immediately.
    send(1'b1, 64'h30, 8'd7, 32'd0);
    wait_ack(8'd7);

    // Table fills exactly with 16 new parents; a 17th is dropped.
    for (int i = 0; i < 16; i++) send(1'b0, 64'h100 + 64'(i), 8'd0, 32'd1);
    wait_idle();
    chk("no_full_at_16", {63'd0, full_err}, 64'd0);
    send(1'b0, 64'h200, 8'd0, 32'd1);
    wait_idle();
    chk("full_at_17", {63'd0, full_err}, 64'd1);
    send(1'b0, 64'h100, 8'd0, 32'd1);
    send(1'b1, 64'h100, 8'd9, 32'd2);
    wait_ack(8'd9);

    // Backpressure: ACK held for ten cycles.
    ack_ready = 1'b0;
    send(1'b1, 64'h101, 8'd4, 32'd1);
    wait_ack(8'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ack_valid", {63'd0, ack_valid}, 64'd1);
      chk("bp_ack_accid", {56'd0, ack_accid}, 64'd4);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    ack_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_released_ack", {63'd0, ack_valid}, 64'd0);
    chk("bp_released_rdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Reset while an ACK is pending discards everything.
    ack_ready = 1'b0;
    send(1'b1, 64'h102, 8'd6, 32'd1);
    wait_ack(8'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack_valid", {63'd0, ack_valid}, 64'd0);
    chk("rst_mid_full_err", {63'd0, full_err}, 64'd0);
    @(posedge clk);
    #1;
    ack_ready = 1'b1;
    send(1'b1, 64'h103, 8'd8, 32'd1);
    wait_idle();
    chk("fresh_alloc_no_ack", {63'd0, ack_valid}, 64'd0);
    send(1'b0, 64'h103, 8'd0, 32'd1);
    wait_ack(8'd8);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
